// File: rtl/dma_pkg.sv
// dma_pkg: shared types for the DRAM<->SRAM block-move engine.
//   cmd_t   : 2-bit command encoding presented by the core.
//   state_t : 3-bit FSM state encoding of dma_engine.
//   is_xfer_cmd : true for the two commands that start a transfer.
package dma_pkg;

    typedef enum logic [1:0] {
        CMD_IDLE = 2'b00,
        CMD_D2S  = 2'b01,
        CMD_S2D  = 2'b10,
        CMD_RSVD = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        D2S_RD  = 3'd1,
        D2S_WR  = 3'd2,
        S2D_RD  = 3'd3,
        S2D_CAP = 3'd4,
        S2D_WR  = 3'd5,
        DONE    = 3'd6
    } state_t;

    function automatic logic is_xfer_cmd(input logic [1:0] c);
        return (c == CMD_D2S) || (c == CMD_S2D);
    endfunction

endpackage

// File: rtl/dma_xfer_counter.sv
// dma_xfer_counter: DRAM/SRAM word pointers and remaining-word count.
//   clk, reset      : clock, synchronous active-low reset
//   load, dir       : capture pointers/count at command acceptance
//   advance         : step both pointers by one word, decrement the count
//   src/dest_address, width : command operands
//   dram_ptr/sram_ptr       : current pointers
//   dram_next/sram_next     : pointers one word ahead (wrapping)
//   last            : current word is the final one (rest == 1)
module dma_xfer_counter
    import dma_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int SRAM_AW = 14,
    parameter int LEN_W   = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  cmd_t               dir,
    input  logic               advance,
    input  logic [ADDR_W-1:0]  src_address,
    input  logic [ADDR_W-1:0]  dest_address,
    input  logic [LEN_W-1:0]   width,
    output logic [ADDR_W-1:0]  dram_ptr,
    output logic [SRAM_AW-1:0] sram_ptr,
    output logic [ADDR_W-1:0]  dram_next,
    output logic [SRAM_AW-1:0] sram_next,
    output logic               last
);

    localparam int STRIDE = DATA_W / 8;

    logic [ADDR_W-1:0]  dram_ptr_r;
    logic [SRAM_AW-1:0] sram_ptr_r;
    logic [LEN_W-1:0]   rest_r;

    // Pointer increments wrap naturally through the truncating widths.
    assign dram_next = dram_ptr_r + ADDR_W'(STRIDE);
    assign sram_next = sram_ptr_r + SRAM_AW'(STRIDE);
    assign dram_ptr  = dram_ptr_r;
    assign sram_ptr  = sram_ptr_r;
    assign last      = (rest_r == LEN_W'(1));

    // Pointer and count registers: load on acceptance, step per completed word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dram_ptr_r <= '0;
            sram_ptr_r <= '0;
            rest_r     <= '0;
        end else if (load) begin
            if (dir == CMD_D2S) begin
                dram_ptr_r <= src_address;
                sram_ptr_r <= dest_address[SRAM_AW-1:0];
            end else begin
                dram_ptr_r <= dest_address;
                sram_ptr_r <= src_address[SRAM_AW-1:0];
            end
            rest_r <= width;
        end else if (advance) begin
            dram_ptr_r <= dram_next;
            sram_ptr_r <= sram_next;
            rest_r     <= rest_r - LEN_W'(1);
        end else begin
            dram_ptr_r <= dram_ptr_r;
            sram_ptr_r <= sram_ptr_r;
            rest_r     <= rest_r;
        end
    end

endmodule

// File: rtl/dma_engine.sv
// dma_engine: bidirectional block mover between DRAM (request/valid) and
// synchronous SRAM. Stalls the core for the whole transfer and pulses
// dmaValid for one cycle at completion.
//   clk, reset (sync, active-low), cmd (00 idle, 01 D2S, 10 S2D, 11 ignored)
//   srcAddress, destAddress, width : operands, sampled only in IDLE
//   sramAddress/WriteData/WriteEnable, sramReadData (1-cycle latency)
//   dramAddress/WriteData, dramRead/WriteEnable (held until dramValid),
//   dramReadData, dramValid
//   stall (combinational), dmaValid (registered done pulse)
module dma_engine
    import dma_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int SRAM_AW = 14,
    parameter int LEN_W   = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         cmd,
    input  logic [ADDR_W-1:0]  srcAddress,
    input  logic [ADDR_W-1:0]  destAddress,
    input  logic [LEN_W-1:0]   width,
    input  logic [DATA_W-1:0]  sramReadData,
    output logic [SRAM_AW-1:0] sramAddress,
    output logic [DATA_W-1:0]  sramWriteData,
    output logic               sramWriteEnable,
    output logic [ADDR_W-1:0]  dramAddress,
    output logic [DATA_W-1:0]  dramWriteData,
    output logic               dramReadEnable,
    output logic               dramWriteEnable,
    input  logic [DATA_W-1:0]  dramReadData,
    input  logic               dramValid,
    output logic               stall,
    output logic               dmaValid
);

    state_t             state_r;
    logic [DATA_W-1:0]  data_buf_r;
    logic               load_s;
    logic               advance_s;
    logic               last_s;
    logic [ADDR_W-1:0]  dram_ptr_s;
    logic [ADDR_W-1:0]  dram_next_s;
    logic [SRAM_AW-1:0] sram_ptr_s;
    logic [SRAM_AW-1:0] sram_next_s;

    dma_xfer_counter #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .SRAM_AW (SRAM_AW),
        .LEN_W   (LEN_W)
    ) u_counter (
        .clk          (clk),
        .reset        (reset),
        .load         (load_s),
        .dir          (cmd_t'(cmd)),
        .advance      (advance_s),
        .src_address  (srcAddress),
        .dest_address (destAddress),
        .width        (width),
        .dram_ptr     (dram_ptr_s),
        .sram_ptr     (sram_ptr_s),
        .dram_next    (dram_next_s),
        .sram_next    (sram_next_s),
        .last         (last_s)
    );

    // High during the acceptance cycle too, so the core holds immediately.
    assign stall = (state_r != IDLE) | is_xfer_cmd(cmd);

    // Counter control: load on acceptance, advance once a word is fully written.
    always_comb begin
        load_s    = 1'b0;
        advance_s = 1'b0;
        case (state_r)
            IDLE:    load_s    = is_xfer_cmd(cmd);
            D2S_WR:  advance_s = 1'b1;
            S2D_WR:  advance_s = dramValid;
            default: begin
                load_s    = 1'b0;
                advance_s = 1'b0;
            end
        endcase
    end

    // FSM; outputs are registered by decoding them for the state being entered,
    // so the pointers used are the values the counter holds after this edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r         <= IDLE;
            data_buf_r      <= '0;
            sramAddress     <= '0;
            sramWriteData   <= '0;
            sramWriteEnable <= 1'b0;
            dramAddress     <= '0;
            dramWriteData   <= '0;
            dramReadEnable  <= 1'b0;
            dramWriteEnable <= 1'b0;
            dmaValid        <= 1'b0;
        end else begin
            sramAddress     <= '0;
            sramWriteData   <= '0;
            sramWriteEnable <= 1'b0;
            dramAddress     <= '0;
            dramWriteData   <= '0;
            dramReadEnable  <= 1'b0;
            dramWriteEnable <= 1'b0;
            dmaValid        <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (is_xfer_cmd(cmd)) begin
                        if (width == '0) begin
                            state_r  <= DONE;
                            dmaValid <= 1'b1;
                        end else if (cmd == CMD_D2S) begin
                            state_r        <= D2S_RD;
                            dramReadEnable <= 1'b1;
                            dramAddress    <= srcAddress;
                        end else begin
                            state_r     <= S2D_RD;
                            sramAddress <= srcAddress[SRAM_AW-1:0];
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                D2S_RD: begin
                    if (dramValid) begin
                        data_buf_r      <= dramReadData;
                        state_r         <= D2S_WR;
                        sramWriteEnable <= 1'b1;
                        sramAddress     <= sram_ptr_s;
                        sramWriteData   <= dramReadData;
                    end else begin
                        state_r        <= D2S_RD;
                        dramReadEnable <= 1'b1;
                        dramAddress    <= dram_ptr_s;
                    end
                end
                D2S_WR: begin
                    if (last_s) begin
                        state_r  <= DONE;
                        dmaValid <= 1'b1;
                    end else begin
                        state_r        <= D2S_RD;
                        dramReadEnable <= 1'b1;
                        dramAddress    <= dram_next_s;
                    end
                end
                S2D_RD: begin
                    state_r <= S2D_CAP;
                end
                S2D_CAP: begin
                    // SRAM data for the address shown last cycle is valid now.
                    data_buf_r      <= sramReadData;
                    state_r         <= S2D_WR;
                    dramWriteEnable <= 1'b1;
                    dramAddress     <= dram_ptr_s;
                    dramWriteData   <= sramReadData;
                end
                S2D_WR: begin
                    if (dramValid) begin
                        if (last_s) begin
                            state_r  <= DONE;
                            dmaValid <= 1'b1;
                        end else begin
                            state_r     <= S2D_RD;
                            sramAddress <= sram_next_s;
                        end
                    end else begin
                        state_r         <= S2D_WR;
                        dramWriteEnable <= 1'b1;
                        dramAddress     <= dram_ptr_s;
                        dramWriteData   <= data_buf_r;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_engine.sv
// tb_dma_engine: directed, table-driven bench for dma_engine with a
// behavioural synchronous SRAM and a variable-latency DRAM responder.
module tb_dma_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  cmd;
    logic [31:0] srcAddress, destAddress;
    logic [9:0]  width;
    logic [31:0] sramReadData;
    logic [13:0] sramAddress;
    logic [31:0] sramWriteData;
    logic        sramWriteEnable;
    logic [31:0] dramAddress, dramWriteData;
    logic [31:0] dramReadData = 32'h0;
    logic        dramReadEnable, dramWriteEnable;
    logic        dramValid = 1'b0;
    logic        stall, dmaValid;

    always #5 clk = ~clk;

    dma_engine #(.DATA_W(32), .ADDR_W(32), .SRAM_AW(14), .LEN_W(10)) dut (
        .clk(clk), .reset(reset), .cmd(cmd),
        .srcAddress(srcAddress), .destAddress(destAddress), .width(width),
        .sramReadData(sramReadData), .sramAddress(sramAddress),
        .sramWriteData(sramWriteData), .sramWriteEnable(sramWriteEnable),
        .dramAddress(dramAddress), .dramWriteData(dramWriteData),
        .dramReadEnable(dramReadEnable), .dramWriteEnable(dramWriteEnable),
        .dramReadData(dramReadData), .dramValid(dramValid),
        .stall(stall), .dmaValid(dmaValid)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dram_fn(input logic [31:0] a);
        return a ^ 32'hC3C3_0000;
    endfunction

    function automatic logic [31:0] sram_fn(input int i);
        return 32'h5A00_0000 | 32'(i);
    endfunction

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    acc_t sram_wr_q[$];
    acc_t dram_wr_q[$];

    // Synchronous SRAM model, 4096 words, preset on the first edge.
    logic [31:0] mem [4096];
    logic        mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= sram_fn(i);
            mem_init <= 1'b1;
        end else if (sramWriteEnable) begin
            mem[sramAddress[13:2]] <= sramWriteData;
            sram_wr_q.push_back({18'd0, sramAddress, sramWriteData});
        end
        sramReadData <= mem[sramAddress[13:2]];
    end

    // DRAM responder: dramValid after lat_cur extra cycles; also watches
    // that enables/address/data stay stable while an access waits.
    int          lat_cfg = 0;
    bit          rand_lat = 1'b0;
    int          lat_cur = 0;
    int          cnt = 0;
    int          mon_err = 0;
    int          acc_cycles = 0;
    int          en_cycles = 0;
    logic [31:0] hold_addr, hold_data;
    always @(negedge clk) begin
        if (dramReadEnable || dramWriteEnable) begin
            en_cycles++;
            acc_cycles++;
            if (cnt == 0) begin
                hold_addr = dramAddress;
                hold_data = dramWriteData;
            end else if (dramAddress !== hold_addr || dramWriteData !== hold_data) begin
                mon_err++;
            end
            if (dramReadEnable && dramWriteEnable) mon_err++;
            if (cnt >= lat_cur) begin
                dramValid    = 1'b1;
                dramReadData = dramReadEnable ? dram_fn(dramAddress) : 32'h0;
                if (dramWriteEnable) dram_wr_q.push_back({dramAddress, dramWriteData});
                cnt = 0;
            end else begin
                dramValid    = 1'b0;
                dramReadData = 32'h0;
                cnt++;
            end
        end else begin
            if (cnt != 0 && reset) mon_err++;
            dramValid    = 1'b0;
            dramReadData = 32'h0;
            cnt          = 0;
            lat_cur      = rand_lat ? int'($urandom_range(0, 5)) : lat_cfg;
        end
        if (sramWriteEnable) en_cycles++;
    end

    function automatic logic any_out();
        return |{sramAddress, sramWriteData, sramWriteEnable, dramAddress,
                 dramWriteData, dramReadEnable, dramWriteEnable, stall, dmaValid};
    endfunction

    logic [31:0] shadow [4096];

    // Present a command in cycle 0, then count cycles until dmaValid.
    task automatic run_xfer(input logic [1:0] c, input logic [31:0] s, input logic [31:0] d,
                            input int w, input bit busy, output int cyc);
        @(negedge clk);
        cmd = c; srcAddress = s; destAddress = d; width = 10'(w);
        #1;
        check("stall_accept", stall, 1);
        cyc = 0;
        while (cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (dmaValid) break;
            cmd = busy ? ((cyc % 2 == 1) ? 2'b10 : 2'b11) : 2'b00;
        end
        cmd = busy ? 2'b11 : 2'b00;
    endtask

    task automatic check_data(input logic [1:0] c, input logic [31:0] s, input logic [31:0] d, input int w);
        logic [31:0] a_exp, d_exp, sa;
        if (c == 2'b01) begin
            check("d2s_count", 64'(sram_wr_q.size()), 64'(w));
            for (int i = 0; i < w && i < sram_wr_q.size(); i++) begin
                a_exp = (d + 32'(4 * i)) & 32'h0000_3FFF;
                d_exp = dram_fn(s + 32'(4 * i));
                check("d2s_sram_addr", sram_wr_q[i].addr, a_exp);
                check("d2s_sram_data", sram_wr_q[i].data, d_exp);
                shadow[a_exp[13:2]] = d_exp;
            end
        end else begin
            check("s2d_count", 64'(dram_wr_q.size()), 64'(w));
            for (int i = 0; i < w && i < dram_wr_q.size(); i++) begin
                a_exp = d + 32'(4 * i);
                sa    = s + 32'(4 * i);
                check("s2d_dram_addr", dram_wr_q[i].addr, a_exp);
                check("s2d_dram_data", dram_wr_q[i].data, shadow[sa[13:2]]);
            end
        end
    endtask

    typedef struct {
        logic [1:0]  c;
        logic [31:0] s;
        logic [31:0] d;
        int          w;
        int          lat;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int cyc, en0, acc0, seen;
        vecs[0] = '{2'b01, 32'h0000_1000, 32'h0000_0040, 4, 0, 9};
        vecs[1] = '{2'b10, 32'h0000_3FF8, 32'h0000_2000, 3, 2, 16};
        vecs[2] = '{2'b01, 32'h0000_0800, 32'h0000_0900, 0, 0, 1};
        vecs[3] = '{2'b10, 32'h0000_0010, 32'h8000_0000, 1, 0, 4};
        vecs[4] = '{2'b01, 32'hFFFF_FFFC, 32'h0000_3FFC, 2, 1, 7};
        vecs[5] = '{2'b10, 32'h0000_0100, 32'h0000_0200, 0, 3, 1};
        for (int i = 0; i < 4096; i++) shadow[i] = sram_fn(i);

        reset = 1'b0; cmd = 2'b00; srcAddress = '0; destAddress = '0; width = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'(any_out()), 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            lat_cfg = vecs[i].lat;
            sram_wr_q.delete();
            dram_wr_q.delete();
            en0 = en_cycles;
            run_xfer(vecs[i].c, vecs[i].s, vecs[i].d, vecs[i].w, 1'b0, cyc);
            check("done_cycle", 64'(cyc), 64'(vecs[i].exp_cyc));
            check("stall_in_done", stall, 1);
            @(negedge clk);
            check("stall_after_done", stall, 0);
            check("pulse_one_cycle", dmaValid, 0);
            if (vecs[i].w == 0) check("w0_no_enable", 64'(en_cycles - en0), 0);
            check_data(vecs[i].c, vecs[i].s, vecs[i].d, vecs[i].w);
        end

        // Busy ignore: 10/11 presented throughout a D2S transfer.
        lat_cfg = 0;
        sram_wr_q.delete();
        dram_wr_q.delete();
        run_xfer(2'b01, 32'h0000_0200, 32'h0000_0100, 3, 1'b1, cyc);
        check("busy_done_cycle", 64'(cyc), 7);
        check_data(2'b01, 32'h0000_0200, 32'h0000_0100, 3);
        check("busy_no_dram_wr", 64'(dram_wr_q.size()), 0);
        en0 = en_cycles;
        repeat (3) @(negedge clk);
        check("busy_rsvd_idle_stall", stall, 0);
        check("busy_rsvd_no_enable", 64'(en_cycles - en0), 0);
        check("busy_rsvd_no_done", dmaValid, 0);
        cmd = 2'b00;

        // Reset during D2S_RD of word 2 (Lr=3: word 1 is cycles 1..4).
        lat_cfg = 2;
        sram_wr_q.delete();
        @(negedge clk);
        cmd = 2'b01; srcAddress = 32'h0000_3000; destAddress = 32'h0000_0200; width = 10'd4;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            cmd = 2'b00;
        end
        check("rst_mid_rd_en", dramReadEnable, 1);
        check("rst_mid_rd_addr", dramAddress, 32'h0000_3004);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_outputs_zero", 64'(any_out()), 0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            seen |= int'(dmaValid);
        end
        check("rst_mid_no_done", 64'(seen), 0);
        check("rst_mid_one_write", 64'(sram_wr_q.size()), 1);

        lat_cfg = 0;
        dram_wr_q.delete();
        run_xfer(2'b10, 32'h0000_0020, 32'h0000_4000, 1, 1'b0, cyc);
        check("post_rst_done_cycle", 64'(cyc), 4);
        check_data(2'b10, 32'h0000_0020, 32'h0000_4000, 1);
        @(negedge clk);

        // Variable DRAM latency 0..5 cycles per access.
        rand_lat = 1'b1;
        sram_wr_q.delete();
        acc0 = acc_cycles;
        run_xfer(2'b01, 32'h0000_5000, 32'h0000_0300, 6, 1'b0, cyc);
        check("var_done_cycle", 64'(cyc), 64'((acc_cycles - acc0) + 6 + 1));
        check_data(2'b01, 32'h0000_5000, 32'h0000_0300, 6);
        rand_lat = 1'b0;
        @(negedge clk);
        check("dram_wait_stable", 64'(mon_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dma_engine.md
# dma_engine

- Parametrised, bidirectional successor to the single-direction DMA controller.
- Moves a block of words between external DRAM and on-chip SRAM, in either direction, under a 2-bit command from the core.
- Sits between the core's DMA command registers and the DRAM/SRAM ports, on the DRAM side through the existing request/valid adapter.
- Stalls the core for the whole transfer and signals completion with a one-cycle pulse.

## Interface
- DATA_W, 32: word width; byte stride per word = DATA_W/8.
- ADDR_W, 32: DRAM byte-address width.
- SRAM_AW, 14: SRAM byte-address width.
- LEN_W, 10: width of the word-count field.
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-low (reset==0 at a rising edge resets).
- cmd  in  2  00 idle, 01 DRAM→SRAM (D2S), 10 SRAM→DRAM (S2D), 11 reserved (ignored).
- srcAddress, destAddress  in  ADDR_W  byte addresses; only the low SRAM_AW bits are used on the SRAM side.
- width  in  LEN_W  number of words to move.
- sramReadData  in  DATA_W  synchronous SRAM output: valid the cycle after the address.
- sramAddress  out  SRAM_AW
- sramWriteData  out  DATA_W
- sramWriteEnable  out  1
- dramAddress  out  ADDR_W
- dramWriteData  out  DATA_W
- dramReadEnable, dramWriteEnable  out  1  held high until dramValid.
- dramReadData  in  DATA_W  valid in the dramValid cycle.
- dramValid  in  1  completion of the current DRAM access.
- stall  out  1  core must hold.
- dmaValid  out  1  one-cycle done pulse.

## Operation
- cmd, srcAddress, destAddress and width are sampled only in IDLE. Non-idle cmd in any other state is ignored; 11 is ignored in IDLE.
- On acceptance, the engine loads:
  - DRAM pointer = D2S ? src : dest.
  - SRAM pointer = D2S ? dest : src.
  - rest = width.
  - dir = cmd.
- States:
  - IDLE
  - D2S_RD: dramReadEnable=1, dramAddress=DRAM pointer. On dramValid, capture dramReadData into buf, go to D2S_WR.
  - D2S_WR: sramWriteEnable=1 for exactly one cycle, sramAddress=SRAM pointer, sramWriteData=buf. Then advance.
  - S2D_RD: present sramAddress = SRAM pointer, then go to S2D_CAP.
  - S2D_CAP: capture sramReadData into buf, then go to S2D_WR.
  - S2D_WR: dramWriteEnable=1, dramWriteData=buf. Exit on dramValid, then advance.
  - DONE: dmaValid=1, then go to IDLE.
- Advance:
  - Both pointers += DATA_W/8. The DRAM pointer wraps mod 2^ADDR_W; the SRAM pointer wraps mod 2^SRAM_AW.
  - rest -= 1.
  - If the new rest == 0, go to DONE; otherwise go to the direction's first state.
- width==0: IDLE → DONE directly. No memory enable is ever asserted.
- dramValid outside D2S_RD/S2D_WR is ignored.
- All enables are 0 in every state not listed above. Address and data outputs are don't-care when their enable is low; drive them with 0.
- Reset: all outputs 0, state IDLE, pointers/rest/buf 0. This applies mid-transfer as well: enables drop at that edge and no dmaValid pulse is issued.

## Timing
- stall = (state != IDLE) | (state==IDLE & cmd∈{01,10}). It is combinational, so it is high in the acceptance cycle.
- stall falls in the cycle after DONE.
- dmaValid is high in the DONE cycle only, and stall is also high in that cycle.
- Let Lr/Lw be the number of cycles from enable assertion up to and including dramValid (minimum 1).
- D2S cycles per word = Lr + 1.
- S2D cycles per word = 2 + Lw.
- Full transfer: dmaValid occurs N·(per-word) + 1 cycles after the acceptance cycle.
- An enable stays continuously high across wait cycles; it deasserts in the cycle after dramValid.
- A new command may be accepted in the cycle after DONE.

## Structure
- Package dma_pkg holds:
  - the cmd_t enum (CMD_IDLE, CMD_D2S, CMD_S2D, CMD_RSVD);
  - the state_t enum (IDLE, D2S_RD, D2S_WR, S2D_RD, S2D_CAP, S2D_WR, DONE), 3 bits.
- Sub-module dma_xfer_counter holds the two pointers and rest. It provides load, advance, a last flag (rest==1) and the parametrised stride/wrap logic.
- The FSM and the output decode live in dma_engine.

## Test plan
- D2S, width=4, src=0x1000, dest=0x0040, dramValid same cycle (Lr=1):
  - SRAM writes to 0x40/0x44/0x48/0x4C with DRAM words from 0x1000..0x100C, in order;
  - dmaValid 9 cycles after acceptance; stall low on cycle 10.
- S2D, width=3, src=0x3FF8, dest=0x2000, Lw=3:
  - SRAM reads 0x3FF8, 0x3FFC, then wraps to 0x0000;
  - DRAM writes to 0x2000/0x2004/0x2008 with the matching data;
  - dmaValid 16 cycles after acceptance.
- width=0 with cmd=01:
  - no enable is ever high;
  - dmaValid on cycle 1; stall high for cycles 0–1 only.
- Busy ignore: cmd=10 and cmd=11 are driven throughout a D2S transfer. The transfer is unaffected, and the engine returns to IDLE accepting nothing until cmd is re-presented.
- Reset mid-transfer: reset=0 during D2S_RD of word 2. The next cycle shows all outputs 0, and no dmaValid. A subsequent S2D, width=1 completes normally.
- Variable latency: D2S with dramValid delayed 0..5 cycles at random. dramReadEnable must stay continuously high and dramAddress stable until dramValid, and the data must match.
